// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer: opcodes, FSM states,
// datapath mux selects and the decoded instruction class.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_EXEC_I = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_MEM_WR = 4'd6,
    S_WB     = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
  } state_e;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_REG    = 2'd3;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_PC  = 2'd2;

  localparam logic [1:0] SRCB_RT   = 2'd0;
  localparam logic [1:0] SRCB_ZEXT = 2'd1;
  localparam logic [1:0] SRCB_SEXT = 2'd2;
  localparam logic [1:0] SRCB_HI   = 2'd3;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_OR   = 3'd2;
  localparam logic [2:0] ALU_PASS = 3'd3;

  typedef enum logic [3:0] {
    CLS_NOP, CLS_ADDU, CLS_SUBU, CLS_JR, CLS_ORI, CLS_LUI,
    CLS_LW, CLS_SW, CLS_BEQ, CLS_JAL, CLS_ILL
  } cls_e;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/funct to instruction class plus an
// unsupported-encoding flag.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output cls_e       cls_o,
  output logic       illegal_o
);

  // NOTE: default assignment first so every path drives cls_o and no latch is inferred.
  always_comb begin
    cls_o = CLS_ILL;
    case (opcode_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADDU: cls_o = CLS_ADDU;
          FN_SUBU: cls_o = CLS_SUBU;
          FN_JR:   cls_o = CLS_JR;
          FN_SLL:  cls_o = CLS_NOP;
          default: cls_o = CLS_ILL;
        endcase
      end
      OP_ORI:  cls_o = CLS_ORI;
      OP_LUI:  cls_o = CLS_LUI;
      OP_LW:   cls_o = CLS_LW;
      OP_SW:   cls_o = CLS_SW;
      OP_BEQ:  cls_o = CLS_BEQ;
      OP_JAL:  cls_o = CLS_JAL;
      default: cls_o = CLS_ILL;
    endcase
  end

  assign illegal_o = (cls_o == CLS_ILL);

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback over a
// shared datapath with a req/ack memory handshake, and counts retired instructions.
module mc_sequencer
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             reg_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wd_sel,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic [3:0]       state_o,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q;
  cls_e             cls_q;
  cls_e             dec_cls;
  logic             dec_illegal;
  logic             active_q;
  logic [CNT_W-1:0] retired_q;
  ctrl_t            ctrl;

  mc_decode u_decode (
    .opcode_i  (opcode),
    .funct_i   (funct),
    .cls_o     (dec_cls),
    .illegal_o (dec_illegal)
  );

  // active_q is cleared asynchronously, so every enable (mem_req included) drops the
  // instant reset asserts, and the first fetch request appears one edge after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      cls_q     <= CLS_NOP;
      active_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update on the same edge.
      active_q <= 1'b1;
      if (ctrl.instr_done) retired_q <= retired_q + CNT_W'(1);
      if (active_q) begin
        case (state_q)
          S_FETCH:  if (mem_ack) state_q <= S_DECODE;
          S_DECODE: begin
            cls_q <= dec_cls;
            case (dec_cls)
              CLS_ADDU, CLS_SUBU: state_q <= S_EXEC_R;
              CLS_ORI, CLS_LUI:   state_q <= S_EXEC_I;
              CLS_LW, CLS_SW:     state_q <= S_ADDR;
              CLS_BEQ:            state_q <= S_BRANCH;
              CLS_JAL, CLS_JR:    state_q <= S_JUMP;
              default:            state_q <= S_FETCH;
            endcase
          end
          S_EXEC_R, S_EXEC_I: state_q <= S_WB;
          S_ADDR:   state_q <= (cls_q == CLS_LW) ? S_MEM_RD : S_MEM_WR;
          S_MEM_RD: if (mem_ack) state_q <= S_WB;
          S_MEM_WR: if (mem_ack) state_q <= S_FETCH;
          default:  state_q <= S_FETCH;
        endcase
      end
    end
  end

  // Outputs are a pure function of the registered state and decoded class; only the
  // ack-qualified enables and the branch pc_we look at live inputs.
  always_comb begin
    ctrl = '0;
    if (active_q) begin
      case (state_q)
        S_FETCH: begin
          ctrl.mem_req = 1'b1;
          ctrl.ir_we   = mem_ack;
          ctrl.pc_we   = mem_ack;
          ctrl.pc_src  = PC_PLUS4;
        end
        S_DECODE: begin
          ctrl.instr_done = (dec_cls == CLS_NOP);
          ctrl.illegal    = dec_illegal;
        end
        S_EXEC_R: begin
          ctrl.alu_src_b = SRCB_RT;
          ctrl.alu_op    = (cls_q == CLS_SUBU) ? ALU_SUB : ALU_ADD;
        end
        S_EXEC_I: begin
          ctrl.alu_src_b = (cls_q == CLS_ORI) ? SRCB_ZEXT : SRCB_HI;
          ctrl.alu_op    = (cls_q == CLS_ORI) ? ALU_OR : ALU_PASS;
        end
        S_ADDR: begin
          ctrl.alu_src_b = SRCB_SEXT;
          ctrl.alu_op    = ALU_ADD;
        end
        S_MEM_RD: begin
          ctrl.mem_req      = 1'b1;
          ctrl.mem_addr_sel = 1'b1;
        end
        S_MEM_WR: begin
          ctrl.mem_req      = 1'b1;
          ctrl.mem_addr_sel = 1'b1;
          ctrl.mem_we       = 1'b1;
          ctrl.instr_done   = mem_ack;
        end
        S_WB: begin
          ctrl.reg_we     = 1'b1;
          ctrl.reg_dst    = (cls_q == CLS_ADDU || cls_q == CLS_SUBU) ? DST_RD : DST_RT;
          ctrl.wd_sel     = (cls_q == CLS_LW) ? WD_MEM : WD_ALU;
          ctrl.instr_done = 1'b1;
        end
        S_BRANCH: begin
          ctrl.alu_src_b  = SRCB_RT;
          ctrl.alu_op     = ALU_SUB;
          ctrl.pc_we      = zero;
          ctrl.pc_src     = PC_BRANCH;
          ctrl.instr_done = 1'b1;
        end
        S_JUMP: begin
          ctrl.pc_we      = 1'b1;
          ctrl.instr_done = 1'b1;
          if (cls_q == CLS_JAL) begin
            ctrl.pc_src  = PC_JUMP;
            ctrl.reg_we  = 1'b1;
            ctrl.reg_dst = DST_RA;
            ctrl.wd_sel  = WD_PC;
          end else begin
            ctrl.pc_src = PC_REG;
          end
        end
        default: ctrl = '0;
      endcase
    end
  end

  assign mem_req      = ctrl.mem_req;
  assign mem_we       = ctrl.mem_we;
  assign mem_addr_sel = ctrl.mem_addr_sel;
  assign ir_we        = ctrl.ir_we;
  assign pc_we        = ctrl.pc_we;
  assign pc_src       = ctrl.pc_src;
  assign reg_we       = ctrl.reg_we;
  assign reg_dst      = ctrl.reg_dst;
  assign wd_sel       = ctrl.wd_sel;
  assign alu_src_b    = ctrl.alu_src_b;
  assign alu_op       = ctrl.alu_op;
  assign instr_done   = ctrl.instr_done;
  assign illegal      = ctrl.illegal;
  assign state_o      = state_q;
  assign retired      = retired_q;

endmodule

// File: doc/mc_sequencer.md
Name: mc_sequencer

Overview:
Multi-cycle control FSM that sequences the shared MIPS datapath (single ALU, single unified memory port) through fetch, decode, execute, memory and writeback phases. It sits beside the datapath under the mips top, drives every datapath enable and mux select, and performs a req/ack handshake with the memory so fetch and load/store may stall for any number of cycles. It also counts retired instructions for the bench.

Parameters:
CNT_W, 32, width of retired-instruction counter (wraps at 2^CNT_W).

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
opcode  input  6  IR[31:26] from datapath
funct  input  6  IR[5:0] from datapath
zero  input  1  ALU zero flag, valid in BRANCH
mem_ack  input  1  memory completed current request
mem_req  output  1  memory request, held until mem_ack
mem_we  output  1  request is a write, valid with mem_req
mem_addr_sel  output  1  0=PC, 1=ALU result register
ir_we  output  1  load IR from memory read data
pc_we  output  1  PC write enable
pc_src  output  2  0=PC+4, 1=branch target, 2=jump {PC[31:28],imm26,00}, 3=GPR[rs]
reg_we  output  1  GRF write enable
reg_dst  output  2  0=rt, 1=rd, 2=$31
wd_sel  output  2  0=ALU result, 1=memory data, 2=PC (already PC+4)
alu_src_b  output  2  0=GPR[rt], 1=zext imm16, 2=sext imm16, 3=imm16<<16
alu_op  output  3  0=add, 1=sub, 2=or, 3=pass B
state_o  output  4  current state encoding
instr_done  output  1  one-cycle pulse when an instruction retires
illegal  output  1  one-cycle pulse on unsupported opcode/funct
retired  output  CNT_W  retired-instruction count

Behaviour:
- Supported: addu(000000/100001), subu(000000/100011), jr(000000/001000), ori(001101), lui(001111), lw(100011), sw(101011), beq(000100), jal(000011). nop (all-zero word) decodes as illegal-free no-op: funct 000000 R-type treated as sll $0 → goes to FETCH, retires.
- States: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, ADDR=4, MEM_RD=5, MEM_WR=6, WB=7, BRANCH=8, JUMP=9.
- Moore outputs from state (plus decoded class in WB/JUMP, zero in BRANCH); all outputs not listed for a state are 0.
- FETCH: mem_req=1, mem_addr_sel=0; wait while !mem_ack; on ack: ir_we=1, pc_we=1, pc_src=0, next DECODE.
- DECODE: no enables. R addu/subu→EXEC_R; nop→FETCH (instr_done); ori/lui→EXEC_I; lw/sw→ADDR; beq→BRANCH; jal/jr→JUMP; else illegal=1, →FETCH, not retired.
- EXEC_R: alu_src_b=0, alu_op=add/sub →WB. EXEC_I: ori alu_src_b=1 op=or; lui alu_src_b=3 op=pass →WB.
- ADDR: alu_src_b=2, op=add; lw→MEM_RD, sw→MEM_WR.
- MEM_RD: mem_req=1, mem_addr_sel=1, hold until ack →WB. MEM_WR: same plus mem_we=1; on ack instr_done, →FETCH.
- WB: reg_we=1; R: reg_dst=1,wd_sel=0; ori/lui: reg_dst=0,wd_sel=0; lw: reg_dst=0,wd_sel=1; instr_done, →FETCH.
- BRANCH: alu_src_b=0, op=sub; pc_we=zero, pc_src=1; instr_done, →FETCH.
- JUMP: pc_we=1; jal: pc_src=2, reg_we=1, reg_dst=2, wd_sel=2; jr: pc_src=3; instr_done, →FETCH.
- Latency with immediate ack: R/ori/lui/sw 4 cycles, lw 5, beq/jal/jr 3; each stall cycle adds one.
- mem_ack while mem_req=0: ignored. mem_req/mem_we/mem_addr_sel stable while waiting.
- retired increments on the cycle instr_done=1; wraps to 0 after all-ones.
- Reset low (any time, mid-stall included): state→FETCH, retired→0, all outputs 0 immediately (mem_req dropped asynchronously) and held 0 while reset low; first fetch request the cycle after reset deasserts.

Decomposition:
- Package mc_pkg: opcode/funct constants, state encoding, pc_src/reg_dst/wd_sel/alu_src_b/alu_op encodings, instruction-class enum.
- Sub-module mc_decode: combinational opcode/funct → class + illegal flag; FSM and counter stay in mc_sequencer.

Test Plan:
- Reset low mid-FETCH stall with mem_req=1 → mem_req=0 same cycle, state_o=0, retired=0; release → mem_req=1 next edge.
- addu (000000/100001), ack immediate → states 0,1,2,7; WB: reg_we=1, reg_dst=1, wd_sel=0; retired 0→1 after 4 cycles.
- lw (100011), ack delayed 3 cycles in MEM_RD → MEM_RD held 4 cycles, mem_addr_sel=1, mem_we=0; WB wd_sel=1; total 8 cycles.
- beq zero=1 then zero=0 → BRANCH pc_we=1/pc_src=1 vs pc_we=0; both retire, 3 cycles each.
- jal → JUMP pc_src=2, reg_we=1, reg_dst=2, wd_sel=2; jr → pc_src=3, reg_we=0.
- opcode 111111 → illegal pulse in DECODE, back to FETCH, retired unchanged; counter preset run of 2^CNT_W retires (CNT_W=4, 16 nops) wraps to 0.
